// File: rtl/cpu_mem_pkg.sv
// Shared definitions for the LSU data-RAM interface: access sizes,
// byte-enable codes, FSM states and small encode helpers.
package cpu_mem_pkg;

   typedef enum logic [1:0] {
      SZ_B = 2'b00,
      SZ_H = 2'b01,
      SZ_W = 2'b10,
      SZ_X = 2'b11
   } size_e;

   // Data-RAM byte-enable codes (an encoded lane selector, not a bitmask)
   localparam logic [3:0] BE_WORD    = 4'b0001;
   localparam logic [3:0] BE_HALF_LO = 4'b0011;
   localparam logic [3:0] BE_HALF_HI = 4'b0010;
   localparam logic [3:0] BE_B0      = 4'b1000;
   localparam logic [3:0] BE_B1      = 4'b1001;
   localparam logic [3:0] BE_B2      = 4'b1010;
   localparam logic [3:0] BE_B3      = 4'b1100;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_REQ  = 2'b01,
      ST_RESP = 2'b10
   } state_e;

   // Size 11 is illegal and is reported exactly like a misaligned access
   function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
      logic bad;
      case (size)
         SZ_B:    bad = 1'b0;
         SZ_H:    bad = off[0];
         SZ_W:    bad = (off != 2'b00);
         default: bad = 1'b1;
      endcase
      return bad;
   endfunction

   function automatic logic [3:0] be_code(input logic [1:0] size, input logic [1:0] off);
      logic [3:0] be;
      case (size)
         SZ_W:    be = BE_WORD;
         SZ_H:    be = (off == 2'b10) ? BE_HALF_HI : BE_HALF_LO;
         SZ_B: begin
            case (off)
               2'b00:   be = BE_B0;
               2'b01:   be = BE_B1;
               2'b10:   be = BE_B2;
               default: be = BE_B3;
            endcase
         end
         default: be = 4'b0000;
      endcase
      return be;
   endfunction

   // Byte stores stay on the low lane; the RAM steers them using the BE code
   function automatic logic [31:0] place_wdata(input logic [1:0] size, input logic [1:0] off,
                                               input logic [31:0] wdata);
      logic [31:0] d;
      case (size)
         SZ_W:    d = wdata;
         SZ_H:    d = (off == 2'b10) ? {wdata[15:0], 16'h0000} : {16'h0000, wdata[15:0]};
         default: d = {24'h000000, wdata[7:0]};
      endcase
      return d;
   endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Combinational load-data extraction: selects the byte/half at the access
// offset from the little-endian bus word and sign- or zero-extends it.
module lsu_load_align
   import cpu_mem_pkg::*;
(
   input  logic [31:0] i_rdata,
   input  logic [1:0]  i_offset,
   input  logic [1:0]  i_size,
   input  logic        i_unsigned,
   output logic [31:0] o_data
);

   logic [31:0] w_shift;
   logic        w_sign_b;
   logic        w_sign_h;

   // Shift the addressed lane down to bit 0, then extend to 32 bits
   always_comb begin
      w_shift  = i_rdata >> {i_offset, 3'b000};
      w_sign_b = ~i_unsigned & w_shift[7];
      w_sign_h = ~i_unsigned & w_shift[15];
      o_data   = w_shift;
      case (i_size)
         SZ_B:    o_data = {{24{w_sign_b}}, w_shift[7:0]};
         SZ_H:    o_data = {{16{w_sign_h}}, w_shift[15:0]};
         default: o_data = i_rdata;
      endcase
   end

endmodule

// File: rtl/lsu_data_if.sv
// LSU bus initiator: accepts one memory op at a time from the pipeline,
// runs the req/gnt/rvalid handshake on the data-RAM port, and returns
// aligned load data, misalignment and timeout indications.
module lsu_data_if
   import cpu_mem_pkg::*;
#(
   parameter int TIMEOUT = 16,
   parameter int ADDR_W  = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              lsu_valid_i,
   output logic              lsu_ready_o,
   input  logic              lsu_we_i,
   input  logic [1:0]        lsu_size_i,
   input  logic              lsu_unsigned_i,
   input  logic [ADDR_W-1:0] lsu_addr_i,
   input  logic [31:0]       lsu_wdata_i,
   input  logic [4:0]        lsu_rd_i,
   output logic              lsu_busy_o,
   output logic              wb_valid_o,
   output logic [4:0]        wb_rd_o,
   output logic [31:0]       wb_data_o,
   output logic              err_misalign_o,
   output logic              err_timeout_o,
   output logic              data_req_o,
   output logic [ADDR_W-1:0] data_add_o,
   output logic              data_we_o,
   output logic [3:0]        data_be_o,
   output logic [31:0]       data_wdata_o,
   output logic [4:0]        rd_in_data,
   input  logic              data_gnt_i,
   input  logic              data_rvalid_i,
   input  logic [31:0]       data_rdata_i,
   input  logic [4:0]        rd_out_data
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   state_e            r_state, w_state_next;
   logic [CNT_W-1:0]  r_cnt, w_cnt_next;
   logic              r_live, w_live_next;
   logic              r_req, w_req_next;
   logic [ADDR_W-1:0] r_addr, w_addr_next;
   logic              r_we, w_we_next;
   logic [3:0]        r_be, w_be_next;
   logic [31:0]       r_wdata, w_wdata_next;
   logic [4:0]        r_rd, w_rd_next;
   logic [1:0]        r_size, w_size_next;
   logic              r_uns, w_uns_next;
   logic              r_wb_valid, w_wb_valid_next;
   logic [4:0]        r_wb_rd, w_wb_rd_next;
   logic [31:0]       r_wb_data, w_wb_data_next;
   logic              r_err_mis, w_err_mis_next;
   logic              r_err_to, w_err_to_next;
   logic [31:0]       w_align_data;
   logic              w_unused;

   // The RAM's echoed tag carries no function here; it is observed only externally
   assign w_unused = ^rd_out_data;

   lsu_load_align u_align (
      .i_rdata    (data_rdata_i),
      .i_offset   (r_addr[1:0]),
      .i_size     (r_size),
      .i_unsigned (r_uns),
      .o_data     (w_align_data)
   );

   // Next-state and next-output logic for the IDLE/REQ/RESP handshake
   always_comb begin
      w_state_next    = r_state;
      w_cnt_next      = r_cnt;
      w_live_next     = 1'b1;
      w_req_next      = r_req;
      w_addr_next     = r_addr;
      w_we_next       = r_we;
      w_be_next       = r_be;
      w_wdata_next    = r_wdata;
      w_rd_next       = r_rd;
      w_size_next     = r_size;
      w_uns_next      = r_uns;
      w_wb_valid_next = 1'b0;
      w_wb_rd_next    = r_wb_rd;
      w_wb_data_next  = r_wb_data;
      w_err_mis_next  = 1'b0;
      w_err_to_next   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (lsu_valid_i && r_live) begin
               if (is_misaligned(lsu_size_i, lsu_addr_i[1:0])) begin
                  w_err_mis_next = 1'b1;
               end else begin
                  w_state_next = ST_REQ;
                  w_cnt_next   = '0;
                  w_req_next   = 1'b1;
                  w_addr_next  = lsu_addr_i;
                  w_we_next    = lsu_we_i;
                  w_be_next    = be_code(lsu_size_i, lsu_addr_i[1:0]);
                  w_wdata_next = lsu_we_i ? place_wdata(lsu_size_i, lsu_addr_i[1:0], lsu_wdata_i)
                                          : 32'h0000_0000;
                  w_rd_next    = lsu_rd_i;
                  w_size_next  = lsu_size_i;
                  w_uns_next   = lsu_unsigned_i;
               end
            end
         end
         ST_REQ: begin
            if (data_gnt_i) begin
               w_req_next = 1'b0;
               w_cnt_next = '0;
               if (r_we) begin
                  w_state_next = ST_IDLE;
               end else if (data_rvalid_i) begin
                  w_state_next    = ST_IDLE;
                  w_wb_valid_next = 1'b1;
                  w_wb_rd_next    = r_rd;
                  w_wb_data_next  = w_align_data;
               end else begin
                  w_state_next = ST_RESP;
               end
            end else if (r_cnt == CNT_LAST) begin
               w_req_next    = 1'b0;
               w_err_to_next = 1'b1;
               w_state_next  = ST_IDLE;
            end else begin
               w_cnt_next = r_cnt + 1'b1;
            end
         end
         ST_RESP: begin
            if (data_rvalid_i) begin
               w_state_next    = ST_IDLE;
               w_wb_valid_next = 1'b1;
               w_wb_rd_next    = r_rd;
               w_wb_data_next  = w_align_data;
            end else if (r_cnt == CNT_LAST) begin
               w_err_to_next = 1'b1;
               w_state_next  = ST_IDLE;
            end else begin
               w_cnt_next = r_cnt + 1'b1;
            end
         end
         default: begin
            w_state_next = ST_IDLE;
            w_req_next   = 1'b0;
         end
      endcase
   end

   // State and output registers; reset abandons any transaction silently
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ST_IDLE;
         r_cnt      <= '0;
         r_live     <= 1'b0;
         r_req      <= 1'b0;
         r_addr     <= '0;
         r_we       <= 1'b0;
         r_be       <= 4'b0000;
         r_wdata    <= 32'h0000_0000;
         r_rd       <= 5'd0;
         r_size     <= 2'b00;
         r_uns      <= 1'b0;
         r_wb_valid <= 1'b0;
         r_wb_rd    <= 5'd0;
         r_wb_data  <= 32'h0000_0000;
         r_err_mis  <= 1'b0;
         r_err_to   <= 1'b0;
      end else begin
         r_state    <= w_state_next;
         r_cnt      <= w_cnt_next;
         r_live     <= w_live_next;
         r_req      <= w_req_next;
         r_addr     <= w_addr_next;
         r_we       <= w_we_next;
         r_be       <= w_be_next;
         r_wdata    <= w_wdata_next;
         r_rd       <= w_rd_next;
         r_size     <= w_size_next;
         r_uns      <= w_uns_next;
         r_wb_valid <= w_wb_valid_next;
         r_wb_rd    <= w_wb_rd_next;
         r_wb_data  <= w_wb_data_next;
         r_err_mis  <= w_err_mis_next;
         r_err_to   <= w_err_to_next;
      end
   end

   // r_live keeps ready low while reset is held so every output reads 0
   assign lsu_ready_o    = r_live && (r_state == ST_IDLE);
   assign lsu_busy_o     = (r_state != ST_IDLE);
   assign wb_valid_o     = r_wb_valid;
   assign wb_rd_o        = r_wb_rd;
   assign wb_data_o      = r_wb_data;
   assign err_misalign_o = r_err_mis;
   assign err_timeout_o  = r_err_to;
   assign data_req_o     = r_req;
   assign data_add_o     = r_addr;
   assign data_we_o      = r_we;
   assign data_be_o      = r_be;
   assign data_wdata_o   = r_wdata;
   assign rd_in_data     = r_rd;

endmodule
